// File: rtl/reg_access_sequencer.sv
// Register-file front end: queues writebacks, arbitrates the shared rd pin between
// operand reads and FIFO drains, and forwards pending writes to operand reads.
module reg_access_sequencer #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 1,
  parameter int WB_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdReqValid,
  output logic                      rdReqReady,
  input  logic [ADDR_W-1:0]         rdReqRd,
  input  logic [ADDR_W-1:0]         rdReqRs,
  output logic                      rspValid,
  output logic [DATA_W-1:0]         rspOp0,
  output logic [DATA_W-1:0]         rspOp1,
  input  logic                      wbValid,
  output logic                      wbReady,
  input  logic [ADDR_W-1:0]         wbAddr,
  input  logic [DATA_W-1:0]         wbData,
  output logic [ADDR_W-1:0]         rfRd,
  output logic [ADDR_W-1:0]         rfRs,
  output logic                      rfRegWrite,
  output logic [DATA_W-1:0]         rfWriteData,
  input  logic [DATA_W-1:0]         rfOutData0,
  input  logic [DATA_W-1:0]         rfOutData1,
  output logic [$clog2(WB_DEPTH):0] pendingCount
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {ACT_IDLE, ACT_READ, ACT_DRAIN} act_t;

  function automatic logic [STV_W-1:0] sat_inc(input logic [STV_W-1:0] v);
    return (v == STV_MAX) ? v : v + 1'b1;
  endfunction

  logic [ADDR_W-1:0] fifo_addr [WB_DEPTH];
  logic [DATA_W-1:0] fifo_data [WB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [STV_W-1:0]  starve;
  act_t              act;
  logic              full;
  logic              starved;
  logic              nonempty;
  logic              push;
  logic              pop;
  logic              read_fire;
  logic [DATA_W-1:0] fwd0;
  logic [DATA_W-1:0] fwd1;
  logic              rsp_vld_p1;
  logic [DATA_W-1:0] rsp_op0_p1;
  logic [DATA_W-1:0] rsp_op1_p1;

  assign full       = (count == FULL_CNT);
  assign starved    = (starve == STV_MAX);
  assign nonempty   = (count != '0);
  assign rdReqReady = !(full || starved);
  assign wbReady    = !full;
  assign push       = wbValid && !full;
  assign pop        = (act == ACT_DRAIN);
  assign read_fire  = (act == ACT_READ);

  // Only one user of the rd pin per cycle; pending writes win when forced or when nobody reads.
  always_comb begin
    act = ACT_IDLE;
    if (full || starved || (nonempty && !rdReqValid)) begin
      act = ACT_DRAIN;
    end else if (rdReqValid) begin
      act = ACT_READ;
    end
  end

  always_comb begin
    rfRegWrite  = 1'b0;
    rfRd        = rdReqRd;
    rfWriteData = '0;
    if (act == ACT_DRAIN) begin
      rfRegWrite  = 1'b1;
      rfRd        = fifo_addr[rd_ptr];
      rfWriteData = fifo_data[rd_ptr];
    end
  end

  assign rfRs = rdReqRs;

  // Walk oldest to newest so the newest matching pending entry overrides the RF value.
  always_comb begin
    fwd0 = rfOutData0;
    fwd1 = rfOutData1;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        if (fifo_addr[rd_ptr + PTR_W'(i)] == rdReqRd) fwd0 = fifo_data[rd_ptr + PTR_W'(i)];
        if (fifo_addr[rd_ptr + PTR_W'(i)] == rdReqRs) fwd1 = fifo_data[rd_ptr + PTR_W'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wbAddr;
      fifo_data[wr_ptr] <= wbData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (pop || !nonempty) begin
        starve <= '0;
      end else if (read_fire) begin
        starve <= sat_inc(starve);
      end
    end
  end

  // Response stage: operands registered one cycle after the accepting cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_p1 <= 1'b0;
      rsp_op0_p1 <= '0;
      rsp_op1_p1 <= '0;
    end else begin
      rsp_vld_p1 <= read_fire;
      if (read_fire) begin
        rsp_op0_p1 <= fwd0;
        rsp_op1_p1 <= fwd1;
      end
    end
  end

  assign rspValid     = rsp_vld_p1;
  assign rspOp0       = rsp_op0_p1;
  assign rspOp1       = rsp_op1_p1;
  assign pendingCount = count;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Bench for reg_access_sequencer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_reg_access_sequencer;

  localparam int DATA_W       = 8;
  localparam int ADDR_W       = 1;
  localparam int WB_DEPTH     = 4;
  localparam int STARVE_LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rdReqValid = 1'b0;
  logic       rdReqReady;
  logic [0:0] rdReqRd = '0;
  logic [0:0] rdReqRs = '0;
  logic       rspValid;
  logic [7:0] rspOp0;
  logic [7:0] rspOp1;
  logic       wbValid = 1'b0;
  logic       wbReady;
  logic [0:0] wbAddr = '0;
  logic [7:0] wbData = '0;
  logic [0:0] rfRd;
  logic [0:0] rfRs;
  logic       rfRegWrite;
  logic [7:0] rfWriteData;
  logic [7:0] rfOutData0;
  logic [7:0] rfOutData1;
  logic [2:0] pendingCount;

  logic [7:0] rf_env [2] = '{8'h00, 8'h00};

  typedef struct packed {
    logic [0:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t       q[$];
  int         m_starve = 0;
  logic       m_rv = 1'b0;
  logic [7:0] m_op0 = 8'h00;
  logic [7:0] m_op1 = 8'h00;
  logic [7:0] mrf [2] = '{8'h00, 8'h00};

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  reg_access_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rdReqValid(rdReqValid), .rdReqReady(rdReqReady), .rdReqRd(rdReqRd), .rdReqRs(rdReqRs),
    .rspValid(rspValid), .rspOp0(rspOp0), .rspOp1(rspOp1),
    .wbValid(wbValid), .wbReady(wbReady), .wbAddr(wbAddr), .wbData(wbData),
    .rfRd(rfRd), .rfRs(rfRs), .rfRegWrite(rfRegWrite), .rfWriteData(rfWriteData),
    .rfOutData0(rfOutData0), .rfOutData1(rfOutData1), .pendingCount(pendingCount)
  );

  // Register file seen by the DUT: combinational reads, write on the rising edge.
  always @(posedge clk) if (rfRegWrite) rf_env[rfRd] <= rfWriteData;
  assign rfOutData0 = rf_env[rfRd];
  assign rfOutData1 = rf_env[rfRs];

  function void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endfunction

  function logic [7:0] lookup(input logic [0:0] a);
    logic [7:0] r;
    r = mrf[a];
    for (int i = 0; i < q.size(); i++) if (q[i].a == a) r = q[i].d;
    return r;
  endfunction

  // Reference model: checks this cycle's outputs, then predicts the coming clock edge.
  int   n;
  bit   full, starved, drain, rd_ok, push_ok;
  ent_t hd;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_starve = 0;
      m_rv = 1'b0;
      m_op0 = 8'h00;
      m_op1 = 8'h00;
      chk("rst_rfRegWrite", rfRegWrite, 0);
      chk("rst_pendingCount", pendingCount, 0);
      chk("rst_rspValid", rspValid, 0);
      chk("rst_rspOp0", rspOp0, 0);
      chk("rst_rspOp1", rspOp1, 0);
    end else begin
      n = q.size();
      full = (n == WB_DEPTH);
      starved = (m_starve == STARVE_LIMIT);
      drain = full || starved || (n > 0 && !rdReqValid);
      rd_ok = rdReqValid && !drain;
      push_ok = wbValid && (n < WB_DEPTH);
      chk("rdReqReady", rdReqReady, !(full || starved));
      chk("wbReady", wbReady, n < WB_DEPTH);
      chk("pendingCount", pendingCount, n);
      chk("rfRegWrite", rfRegWrite, drain);
      if (drain) begin
        chk("rfRd_drain", rfRd, q[0].a);
        chk("rfWriteData_drain", rfWriteData, q[0].d);
      end else begin
        chk("rfRd_read", rfRd, rdReqRd);
        chk("rfWriteData_idle", rfWriteData, 0);
      end
      chk("rfRs", rfRs, rdReqRs);
      chk("rspValid", rspValid, m_rv);
      chk("rspOp0", rspOp0, m_op0);
      chk("rspOp1", rspOp1, m_op1);
      if (rd_ok) begin
        m_op0 = lookup(rdReqRd);
        m_op1 = lookup(rdReqRs);
      end
      m_rv = rd_ok;
      if (drain) begin
        hd = q.pop_front();
        mrf[hd.a] = hd.d;
      end
      if (push_ok) q.push_back('{a: wbAddr, d: wbData});
      if (drain || n == 0) m_starve = 0;
      else if (rd_ok && m_starve < STARVE_LIMIT) m_starve++;
    end
  end

  task automatic set_in(input logic rv, input logic [0:0] rd, input logic [0:0] rs,
                        input logic wv, input logic [0:0] wa, input logic [7:0] wd);
    rdReqValid = rv;
    rdReqRd = rd;
    rdReqRs = rs;
    wbValid = wv;
    wbAddr = wa;
    wbData = wd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] saved0, saved1;

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("lit_reset_rfRegWrite", rfRegWrite, 0);
    chk("lit_reset_rspValid", rspValid, 0);
    chk("lit_reset_wbReady", wbReady, 1);
    chk("lit_reset_rdReqReady", rdReqReady, 1);
    chk("lit_reset_pendingCount", pendingCount, 0);

    // single writeback with no reads drains the next cycle
    set_in(0, 0, 0, 1, 1, 8'hA5);
    tick();
    set_in(0, 0, 0, 0, 0, 8'h00);
    #1;
    chk("lit_wb_rfRegWrite", rfRegWrite, 1);
    chk("lit_wb_rfRd", rfRd, 1);
    chk("lit_wb_rfWriteData", rfWriteData, 8'hA5);
    tick();
    chk("lit_wb_count0", pendingCount, 0);
    chk("lit_wb_rf1", rf_env[1], 8'hA5);

    // read the cycle after a push forwards the pending value
    set_in(0, 0, 0, 1, 0, 8'h3C);
    tick();
    set_in(1, 0, 0, 0, 0, 8'h00);
    tick();
    chk("lit_fwd_rspValid", rspValid, 1);
    chk("lit_fwd_rspOp0", rspOp0, 8'h3C);
    chk("lit_fwd_rspOp1", rspOp1, 8'h3C);
    chk("lit_fwd_rf0_old", rf_env[0], 8'h00);
    set_in(0, 0, 0, 0, 0, 8'h00);
    repeat (2) tick();

    // newest of two pending writes to the same register wins
    set_in(1, 0, 0, 1, 1, 8'h11);
    tick();
    set_in(1, 0, 0, 1, 1, 8'h22);
    tick();
    set_in(1, 1, 1, 0, 0, 8'h00);
    tick();
    chk("lit_newest_rspOp1", rspOp1, 8'h22);
    chk("lit_newest_rspOp0", rspOp0, 8'h22);
    set_in(0, 0, 0, 0, 0, 8'h00);
    repeat (3) tick();

    // starvation: 4 accepted reads with one pending entry, then a forced drain
    set_in(0, 0, 0, 1, 0, 8'h5A);
    tick();
    set_in(1, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lit_starve_ready_hi", rdReqReady, 1);
      tick();
    end
    #1;
    chk("lit_starve_ready_lo", rdReqReady, 0);
    chk("lit_starve_drain", rfRegWrite, 1);
    tick();
    chk("lit_starve_ready_back", rdReqReady, 1);
    chk("lit_starve_count", pendingCount, 0);

    // fill the FIFO under continuous reads, then reset with entries pending
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 1, 1, 1'(i), 8'h80 + 8'(i));
      tick();
    end
    #1;
    chk("lit_full_wbReady", wbReady, 0);
    chk("lit_full_rdReqReady", rdReqReady, 0);
    chk("lit_full_drain", rfRegWrite, 1);
    chk("lit_full_count", pendingCount, 4);
    tick();
    chk("lit_full_count3", pendingCount, 3);
    saved0 = rf_env[0];
    saved1 = rf_env[1];
    set_in(0, 0, 0, 0, 0, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_count", pendingCount, 0);
    chk("lit_rst_regwrite", rfRegWrite, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lit_post_rst_regwrite", rfRegWrite, 0);
      tick();
    end
    chk("lit_post_rst_rf0", rf_env[0], saved0);
    chk("lit_post_rst_rf1", rf_env[1], saved1);

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        set_in(0, 0, 0, 0, 0, 8'h00);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        set_in(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 1) != 0), 1'($urandom), 8'($urandom));
        tick();
      end
    end
    set_in(0, 0, 0, 0, 0, 8'h00);
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
